// File: rtl/demodulate.sv
// QPSK receiver: per-symbol correlation against cos/sin references, sign decision,
// and an I-then-Q serialiser driving a single bit stream.
module demodulate #(
  parameter int DATA_W  = 10,
  parameter int SPS     = 16,
  parameter int REF_AMP = 127,
  parameter int ACC_W   = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] QPSK_in,
  input  logic                     sym_sync,
  output logic                     Ichannel,
  output logic                     Qchannel,
  output logic                     sym_valid,
  output logic                     bit_stream,
  output logic                     bit_valid
);

  localparam int PH_W   = $clog2(SPS);
  localparam int REF_W  = 8;
  localparam int PROD_W = DATA_W + REF_W;

  localparam logic signed [REF_W-1:0] PEAK       = REF_W'(REF_AMP);
  localparam logic [PH_W-1:0]         LAST_PHASE = PH_W'(SPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_I,
    SEND_Q
  } ser_state_t;

  // round(REF_AMP * cos(2*pi*k/16)); sine is the same table delayed by a quarter period.
  function automatic logic signed [REF_W-1:0] cos_lut(input logic [PH_W-1:0] k);
    case (k)
      4'd0:    cos_lut = PEAK;
      4'd1:    cos_lut = 8'sd117;
      4'd2:    cos_lut = 8'sd90;
      4'd3:    cos_lut = 8'sd49;
      4'd4:    cos_lut = 8'sd0;
      4'd5:    cos_lut = -8'sd49;
      4'd6:    cos_lut = -8'sd90;
      4'd7:    cos_lut = -8'sd117;
      4'd8:    cos_lut = -PEAK;
      4'd9:    cos_lut = -8'sd117;
      4'd10:   cos_lut = -8'sd90;
      4'd11:   cos_lut = -8'sd49;
      4'd12:   cos_lut = 8'sd0;
      4'd13:   cos_lut = 8'sd49;
      4'd14:   cos_lut = 8'sd90;
      4'd15:   cos_lut = 8'sd117;
      default: cos_lut = 8'sd0;
    endcase
  endfunction

  function automatic logic signed [REF_W-1:0] sin_lut(input logic [PH_W-1:0] k);
    sin_lut = cos_lut(k - PH_W'(4));
  endfunction

  // ---------------------------------------------------------------------------
  // Correlator datapath
  // ---------------------------------------------------------------------------
  logic        [PH_W-1:0]   phase;
  logic        [PH_W-1:0]   cur_phase;
  logic signed [PROD_W-1:0] sample_x;
  logic signed [PROD_W-1:0] prod_i;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_i_next;
  logic signed [ACC_W-1:0]  acc_q_next;
  logic                     decide;
  logic                     dec_i;
  logic                     dec_q;

  always_comb begin
    // The sync edge re-labels the sample it captures as phase 0, which also
    // drops any partial sum because phase 0 reloads rather than accumulates.
    cur_phase  = sym_sync ? '0 : phase;
    sample_x   = PROD_W'(QPSK_in);
    prod_i     = sample_x * PROD_W'(cos_lut(cur_phase));
    prod_q     = sample_x * PROD_W'(sin_lut(cur_phase));
    acc_i_next = (cur_phase == '0) ? ACC_W'(prod_i) : acc_i + ACC_W'(prod_i);
    acc_q_next = (cur_phase == '0) ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    decide     = (cur_phase == LAST_PHASE);
    dec_i      = ~acc_i_next[ACC_W-1] & (|acc_i_next);
    dec_q      = ~acc_q_next[ACC_W-1] & (|acc_q_next);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      Ichannel  <= 1'b0;
      Qchannel  <= 1'b0;
      sym_valid <= 1'b0;
    end else begin
      phase     <= decide ? '0 : cur_phase + PH_W'(1);
      acc_i     <= acc_i_next;
      acc_q     <= acc_q_next;
      sym_valid <= decide;
      if (decide) begin
        Ichannel <= dec_i;
        Qchannel <= dec_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  ser_state_t state;
  ser_state_t state_next;
  logic       bit_next;
  logic       bit_valid_next;

  // NOTE: every variable gets a default before the case, otherwise paths that
  // leave it unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    bit_next       = bit_stream;
    bit_valid_next = 1'b0;

    case (state)
      IDLE:    if (decide) state_next = SEND_I;
      SEND_I:  state_next = SEND_Q;
      SEND_Q:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it;
    // the I bit comes straight from the decision being made on this edge.
    case (state_next)
      SEND_I: begin
        bit_next       = dec_i;
        bit_valid_next = 1'b1;
      end
      SEND_Q: begin
        bit_next       = Qchannel;
        bit_valid_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_stream <= 1'b0;
      bit_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_stream <= bit_next;
      bit_valid  <= bit_valid_next;
    end
  end

endmodule

// File: tb/tb_demodulate.sv
// Directed bench for demodulate: stimulus pushes expected decisions and bits into
// queues; a negedge monitor pops and compares whenever the DUT flags valid output.
module tb_demodulate;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [9:0] qpsk_in = '0;
  logic              sym_sync = 1'b0;
  logic              i_ch, q_ch, sym_valid, bit_stream, bit_valid;

  demodulate dut (
    .clk       (clk),
    .rst       (rst),
    .QPSK_in   (qpsk_in),
    .sym_sync  (sym_sync),
    .Ichannel  (i_ch),
    .Qchannel  (q_ch),
    .sym_valid (sym_valid),
    .bit_stream(bit_stream),
    .bit_valid (bit_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   when;
    logic i;
    logic q;
  } sym_exp_t;

  typedef struct {
    int   when;
    logic b;
  } bit_exp_t;

  typedef int vec_t[16];

  sym_exp_t sym_q[$];
  bit_exp_t bit_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // round(200*cos(2*pi*k/16)) and round(200*sin(2*pi*k/16))
  int c200[16] = '{200, 185, 141, 77, 0, -77, -141, -185, -200, -185, -141, -77, 0, 77, 141, 185};
  int s200[16] = '{0, 77, 141, 185, 200, 185, 141, 77, 0, -77, -141, -185, -200, -185, -141, -77};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int si, input int sq);
    vec_t v;
    for (int k = 0; k < 16; k++) v[k] = si * c200[k] + sq * s200[k];
    return v;
  endfunction

  // Drive one sample; it is captured on the next rising edge.
  task automatic drive(input int x, input bit sync);
    @(negedge clk);
    rst      = 1'b0;
    qpsk_in  = 10'(x);
    sym_sync = sync;
  endtask

  // One full symbol; the phase-15 sample's decision is observed one cycle later.
  task automatic send_vec(input vec_t v, input bit sync0, input logic ei, input logic eq,
                          input bit expect_q_bit);
    for (int k = 0; k < 16; k++) begin
      drive(v[k], sync0 && (k == 0));
      if (k == 15) begin
        sym_q.push_back('{when: cyc + 1, i: ei, q: eq});
        bit_q.push_back('{when: cyc + 1, b: ei});
        if (expect_q_bit) bit_q.push_back('{when: cyc + 2, b: eq});
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    sym_sync = 1'b0;
    repeat (3) begin
      @(negedge clk);
      qpsk_in = 10'($urandom_range(1023));
      check("outputs in reset", {27'd0, i_ch, q_ch, sym_valid, bit_stream, bit_valid}, 32'd0);
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    while (sym_q.size() != 0 && sym_q[0].when < cyc) begin
      check("missing sym_valid", 32'(sym_q[0].when), 32'(cyc));
      void'(sym_q.pop_front());
    end
    while (bit_q.size() != 0 && bit_q[0].when < cyc) begin
      check("missing bit_valid", 32'(bit_q[0].when), 32'(cyc));
      void'(bit_q.pop_front());
    end
    if (sym_valid !== 1'b0) begin
      if (sym_q.size() == 0) begin
        check("unexpected sym_valid", 32'(sym_valid), 32'd0);
      end else begin
        sym_exp_t e;
        e = sym_q.pop_front();
        check("sym_valid timing", 32'(cyc), 32'(e.when));
        check("Ichannel", 32'(i_ch), 32'(e.i));
        check("Qchannel", 32'(q_ch), 32'(e.q));
      end
    end
    if (bit_valid !== 1'b0) begin
      if (bit_q.size() == 0) begin
        check("unexpected bit_valid", 32'(bit_valid), 32'd0);
      end else begin
        bit_exp_t b;
        b = bit_q.pop_front();
        check("bit_valid timing", 32'(cyc), 32'(b.when));
        check("bit_stream", 32'(bit_stream), 32'(b.b));
      end
    end
  end

  initial begin
    vec_t v;

    // Reset with random input, then first symbol decided 16 edges after release.
    reset_dut();

    // Four symbols of I=1, Q=1.
    repeat (4) send_vec(mk(1, 1), 1'b0, 1'b1, 1'b1, 1'b1);

    // All four constellation points: serial 1,0 0,1 0,0 1,1.
    send_vec(mk(1, -1), 1'b0, 1'b1, 1'b0, 1'b1);
    send_vec(mk(-1, 1), 1'b0, 1'b0, 1'b1, 1'b1);
    send_vec(mk(-1, -1), 1'b0, 1'b0, 1'b0, 1'b1);
    send_vec(mk(1, 1), 1'b0, 1'b1, 1'b1, 1'b1);

    // All-zero symbol decides 0,0.
    send_vec(mk(0, 0), 1'b0, 1'b0, 1'b0, 1'b1);

    // Extreme amplitudes: accI = 653697 (positive), accQ sums to exactly 0.
    for (int k = 0; k < 16; k++)
      v[k] = (c200[k] > 0) ? 511 : (c200[k] < 0) ? -512 : 0;
    send_vec(v, 1'b0, 1'b1, 1'b0, 1'b1);

    // Sync on a natural phase-0 sample has no visible effect.
    send_vec(mk(-1, 1), 1'b1, 1'b0, 1'b1, 1'b1);

    // Sync at phase 7: partial (-,-) symbol dropped, realigned (+,-) decided.
    v = mk(-1, -1);
    for (int k = 0; k < 7; k++) drive(v[k], 1'b0);
    send_vec(mk(1, -1), 1'b1, 1'b1, 1'b0, 1'b1);
    send_vec(mk(-1, 1), 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset asserted in the SEND_I cycle: I bit seen, Q bit never emitted.
    send_vec(mk(1, 1), 1'b0, 1'b1, 1'b1, 1'b0);
    reset_dut();

    // Recovery after reset.
    send_vec(mk(-1, -1), 1'b0, 1'b0, 1'b0, 1'b1);
    send_vec(mk(1, -1), 1'b0, 1'b1, 1'b0, 1'b1);

    repeat (6) drive(0, 1'b0);
    check("sym queue drained", 32'(sym_q.size()), 32'd0);
    check("bit queue drained", 32'(bit_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
